// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and size-to-lane-mask helper for the load/store unit.
// Build option LSU_MISALIGNED_EN adds the second-beat state used by split accesses.
package lsu_pkg;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
`ifdef LSU_MISALIGNED_EN
        ST_BEAT1 = 2'd2,
`endif
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] lsu_size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane mask, store-data steering and load extraction/extension for the load/store unit.
// With LSU_MISALIGNED_EN the lanes span two words (lo/hi beats).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo,
`ifdef LSU_MISALIGNED_EN
    input  logic [31:0] i_hi,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_wdata_hi,
`endif
    output logic [3:0]  o_be_lo,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_load
);
    logic [3:0]  w_size_mask;
    logic [4:0]  w_shamt;
    logic [31:0] w_rshift;

    assign w_size_mask = lsu_size_mask(i_funct3[1:0]);
    assign w_shamt     = {i_off, 3'b000};

`ifdef LSU_MISALIGNED_EN
    logic [7:0]  w_mask;
    logic [63:0] w_wide;

    // Bytes pushed past the word boundary land in the upper half and form the second beat.
    assign w_mask     = {4'b0000, w_size_mask} << i_off;
    assign w_wide     = {32'h0000_0000, i_wdata} << w_shamt;
    assign o_be_lo    = w_mask[3:0];
    assign o_be_hi    = w_mask[7:4];
    assign o_wdata_lo = w_wide[31:0];
    assign o_wdata_hi = w_wide[63:32];
    assign w_rshift   = 32'({i_hi, i_lo} >> w_shamt);
`else
    assign o_be_lo    = w_size_mask << i_off;
    assign o_wdata_lo = i_wdata << w_shamt;
    assign w_rshift   = i_lo >> w_shamt;
`endif

    // Truncate the lane-aligned read data to the access size and extend it.
    always_comb begin
        case (i_funct3)
            LSU_F3_B:  o_load = {{24{w_rshift[7]}}, w_rshift[7:0]};
            LSU_F3_H:  o_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
            LSU_F3_W:  o_load = w_rshift;
            LSU_F3_BU: o_load = {24'h00_0000, w_rshift[7:0]};
            LSU_F3_HU: o_load = {16'h0000, w_rshift[15:0]};
            default:   o_load = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, byte-enabled word beats, one-cycle response.
// Define LSU_MISALIGNED_EN to split misaligned H/W accesses into two beats instead of faulting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    lsu_state_e        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_wdata;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_lo;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [4:0]        r_rsp_rd;
    logic              r_rsp_fault;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [2:0]        w_funct3;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_lo;
    logic [3:0]        w_be_lo;
    logic [DATA_W-1:0] w_wdata_lo;
    logic [DATA_W-1:0] w_load;
    logic              w_illegal;
    logic              w_fault;
    logic              w_done;

    // In IDLE the lanes are computed from the live request so beat 0 can launch on accept.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_funct3 = req_funct3;
            w_off    = req_addr[1:0];
            w_wdata  = req_wdata;
        end else begin
            w_funct3 = r_funct3;
            w_off    = r_off;
            w_wdata  = r_wdata;
        end
    end

    assign w_lo = (r_state == ST_BEAT0) ? mem_rdata : r_lo;

    // Decode funct3 legality for the incoming request.
    always_comb begin
        case (req_funct3)
            LSU_F3_B, LSU_F3_H, LSU_F3_W: w_illegal = 1'b0;
            LSU_F3_BU, LSU_F3_HU:         w_illegal = req_we;
            default:                      w_illegal = 1'b1;
        endcase
    end

`ifdef LSU_MISALIGNED_EN
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] w_hi;
    logic [3:0]        w_be_hi;
    logic [DATA_W-1:0] w_wdata_hi;
    logic              w_spill;

    assign w_hi    = (r_state == ST_BEAT1) ? mem_rdata : r_hi;
    assign w_fault = w_illegal;
    assign w_spill = mem_ack & (r_state == ST_BEAT0) & (w_be_hi != 4'h0);
    assign w_done  = mem_ack & ((r_state == ST_BEAT0) | (r_state == ST_BEAT1)) & ~w_spill;
`else
    logic w_misal;

    // Flag halfword/word accesses that are not naturally aligned.
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   w_misal = req_addr[0];
            2'b10:   w_misal = (req_addr[1:0] != 2'b00);
            default: w_misal = 1'b0;
        endcase
    end

    assign w_fault = w_illegal | w_misal;
    assign w_done  = mem_ack & (r_state == ST_BEAT0);
`endif

    lsu_align u_align (
        .i_funct3   (w_funct3),
        .i_off      (w_off),
        .i_wdata    (w_wdata),
        .i_lo       (w_lo),
`ifdef LSU_MISALIGNED_EN
        .i_hi       (w_hi),
        .o_be_hi    (w_be_hi),
        .o_wdata_hi (w_wdata_hi),
`endif
        .o_be_lo    (w_be_lo),
        .o_wdata_lo (w_wdata_lo),
        .o_load     (w_load)
    );

    // Request sequencing, memory beats and response generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_wdata     <= {DATA_W{1'b0}};
            r_rd        <= 5'd0;
            r_lo        <= {DATA_W{1'b0}};
`ifdef LSU_MISALIGNED_EN
            r_hi        <= {DATA_W{1'b0}};
`endif
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_rd    <= 5'd0;
            r_rsp_fault <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_be    <= 4'h0;
            r_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        r_rd     <= req_rd;
                        if (w_fault) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_fault <= 1'b1;
                            r_rsp_rdata <= {DATA_W{1'b0}};
                            r_rsp_rd    <= req_rd;
                        end else begin
                            r_state     <= ST_BEAT0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_be    <= w_be_lo;
                            r_mem_wdata <= w_wdata_lo;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BEAT0: begin
                    if (mem_ack) begin
                        r_lo <= mem_rdata;
                    end else begin
                        r_lo <= r_lo;
                    end
                end
`ifdef LSU_MISALIGNED_EN
                ST_BEAT1: begin
                    if (mem_ack) begin
                        r_hi <= mem_rdata;
                    end else begin
                        r_hi <= r_hi;
                    end
                end
`endif
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
`ifdef LSU_MISALIGNED_EN
            if (w_spill) begin
                r_state     <= ST_BEAT1;
                r_mem_addr  <= r_mem_addr + ADDR_W'(3'd4);
                r_mem_be    <= w_be_hi;
                r_mem_wdata <= w_wdata_hi;
            end
`endif
            if (w_done) begin
                r_state     <= ST_RESP;
                r_mem_req   <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {ADDR_W{1'b0}};
                r_mem_be    <= 4'h0;
                r_mem_wdata <= {DATA_W{1'b0}};
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= 1'b0;
                r_rsp_rdata <= r_we ? {DATA_W{1'b0}} : w_load;
                r_rsp_rd    <= r_rd;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE) & ~rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_fault = r_rsp_fault;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboarded memory beats and responses, immediate-assertion checks.
module tb_load_store_unit;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wt;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        fault;
        int          cyc;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    int    nvec = 0;
    int    nfail = 0;
    int    cyc = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_rd     (rsp_rd),
        .rsp_fault  (rsp_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int wt);
        beat_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.rdata = rdata; b.wt = wt;
        beat_q.push_back(b);
    endtask

    // Called at a falling edge; drives one request for one cycle and queues its expected response.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] exp_rdata, input logic exp_fault, input int lat);
        rsp_t r;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        r.rdata = exp_rdata; r.rd = rd; r.fault = exp_fault; r.cyc = cyc + lat;
        rsp_q.push_back(r);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (rsp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout_pending", 32'(rsp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    // Memory model: checks each beat against the queue, holds it for its wait count, then acks.
    initial begin
        beat_t cur;
        bit    in_beat;
        int    wait_left;
        in_beat = 1'b0;
        wait_left = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        cur.we = 1'b0; cur.addr = 32'h0; cur.be = 4'h0; cur.wdata = 32'h0; cur.rdata = 32'h0; cur.wt = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!in_beat) begin
                    chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                    if (beat_q.size() != 0) cur = beat_q.pop_front();
                    in_beat = 1'b1;
                    wait_left = cur.wt;
                end
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_be", 32'(mem_be), 32'(cur.be));
                chk("mem_wdata", mem_wdata, cur.wdata);
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = cur.rdata;
                    in_beat = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = 32'h0;
                    wait_left--;
                end
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 32'h0;
                in_beat = 1'b0;
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the head of the scoreboard.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_rd", 32'(rsp_rd), 32'(r.rd));
                    chk("rsp_fault", 32'(rsp_fault), 32'(r.fault));
                    chk("rsp_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        exp_beat(1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0, 0);
        issue(1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 32'h0, 1'b0, 2);
        wait_done(20);

        exp_beat(1'b0, 32'h0000_0100, 4'h8, 32'h0, 32'h80FF_1234, 0);
        issue(1'b0, F3_B, 32'h0000_0103, 32'h0, 5'd5, 32'hFFFF_FF80, 1'b0, 2);
        wait_done(20);

        exp_beat(1'b0, 32'h0000_0100, 4'h8, 32'h0, 32'h80FF_1234, 2);
        issue(1'b0, F3_BU, 32'h0000_0103, 32'h0, 5'd6, 32'h0000_0080, 1'b0, 4);
        wait_done(20);

        exp_beat(1'b1, 32'h0000_0200, 4'hC, 32'hABCD_0000, 32'h0, 1);
        issue(1'b1, F3_H, 32'h0000_0202, 32'h0000_ABCD, 5'd3, 32'h0, 1'b0, 3);
        wait_done(20);

        exp_beat(1'b0, 32'h0000_0200, 4'hC, 32'h0, 32'h80FF_1234, 0);
        issue(1'b0, F3_H, 32'h0000_0202, 32'h0, 5'd7, 32'hFFFF_80FF, 1'b0, 2);
        wait_done(20);

        exp_beat(1'b0, 32'h0000_0200, 4'h3, 32'h0, 32'h80FF_1234, 0);
        issue(1'b0, F3_HU, 32'h0000_0200, 32'h0, 5'd8, 32'h0000_1234, 1'b0, 2);
        wait_done(20);

        exp_beat(1'b1, 32'h0000_0100, 4'h2, 32'h3456_7800, 32'h0, 0);
        issue(1'b1, F3_B, 32'h0000_0101, 32'h1234_5678, 5'd2, 32'h0, 1'b0, 2);
        wait_done(20);

`ifdef LSU_MISALIGNED_EN
        exp_beat(1'b0, 32'h0000_0FFC, 4'hC, 32'h0, 32'h3344_5566, 0);
        exp_beat(1'b0, 32'h0000_1000, 4'h3, 32'h0, 32'h7788_1122, 0);
        issue(1'b0, F3_W, 32'h0000_0FFE, 32'h0, 5'd10, 32'h1122_3344, 1'b0, 3);
        wait_done(20);

        exp_beat(1'b0, 32'h0000_0200, 4'h6, 32'h0, 32'h80FF_1234, 0);
        issue(1'b0, F3_H, 32'h0000_0201, 32'h0, 5'd11, 32'hFFFF_FF12, 1'b0, 2);
        wait_done(20);

        exp_beat(1'b1, 32'hFFFF_FFFC, 4'hC, 32'hCCDD_0000, 32'h0, 0);
        exp_beat(1'b1, 32'h0000_0000, 4'h3, 32'h0000_AABB, 32'h0, 1);
        issue(1'b1, F3_W, 32'hFFFF_FFFE, 32'hAABB_CCDD, 5'd12, 32'h0, 1'b0, 4);
        wait_done(20);
`else
        issue(1'b0, F3_W, 32'h0000_0FFE, 32'h0, 5'd10, 32'h0, 1'b1, 1);
        wait_done(20);

        issue(1'b0, F3_H, 32'h0000_0201, 32'h0, 5'd11, 32'h0, 1'b1, 1);
        wait_done(20);

        issue(1'b1, F3_W, 32'hFFFF_FFFE, 32'hAABB_CCDD, 5'd12, 32'h0, 1'b1, 1);
        wait_done(20);
`endif

        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd13, 32'h0, 1'b1, 1);
        wait_done(20);
        issue(1'b1, F3_BU, 32'h0000_0100, 32'h0000_00AA, 5'd14, 32'h0, 1'b1, 1);
        wait_done(20);
        issue(1'b0, 3'b111, 32'h0000_0104, 32'h0, 5'd15, 32'h0, 1'b1, 1);
        wait_done(20);

        // Reset while beat 0 waits on a withheld ack: access abandoned, no response.
        exp_beat(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h0, 50);
        chk("req_ready_pre_rst", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0000_0300;
        req_wdata = 32'h0; req_rd = 5'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mem_req_before_rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mem_req_after_rst", 32'(mem_req), 32'd0);
        chk("req_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", 32'(req_ready), 32'd1);

        exp_beat(1'b1, 32'h0000_0104, 4'hF, 32'h0BAD_F00D, 32'h0, 0);
        issue(1'b1, F3_W, 32'h0000_0104, 32'h0BAD_F00D, 5'd4, 32'h0, 1'b0, 2);
        wait_done(20);

        repeat (3) @(negedge clk);
        chk("beats_left", 32'(beat_q.size()), 32'd0);
        chk("rsps_left", 32'(rsp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
